// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared size/tag encodings, arbiter states and byte-enable helper
// for cpu_mem_arbiter.
package cpu_bus_pkg;
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic TAG_IBUS = 1'b1;
   localparam logic TAG_DBUS = 1'b0;
   typedef enum logic [1:0] {ST_IDLE, ST_GNT_I, ST_GNT_D} arb_state_e;
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr);
      return (size == SIZE_B) ? 4'b0001 << addr :
             (size == SIZE_H) ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
   endfunction
endpackage

// File: rtl/rsp_tag_fifo.sv
// rsp_tag_fifo: 1-bit tag FIFO remembering which bus issued each in-flight read.
// Caller guarantees no push when full and no pop when empty.
module rsp_tag_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_,
   input  logic                       push,
   input  logic                       din,
   input  logic                       pop,
   output logic                       head,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   logic          mem_q [DEPTH];
   logic          mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = din;
      wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         mem_q    <= '{default: 1'b0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
   assign head  = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: merges VexRiscv iBus/dBus onto one memory port with up to
// MAX_OUTSTANDING in-order reads. Define CPU_ARB_ROUND_ROBIN_EN for round-robin ties.
module cpu_mem_arbiter
   import cpu_bus_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int DBUS_PRIO       = 1
) (
   input  logic                                 clk,
   input  logic                                 reset_,
   input  logic                                 ibus_cmd_valid,
   output logic                                 ibus_cmd_ready,
   input  logic [ADDR_W-1:0]                    ibus_cmd_pc,
   output logic                                 ibus_rsp_valid,
   output logic [31:0]                          ibus_rsp_inst,
   input  logic                                 dbus_cmd_valid,
   output logic                                 dbus_cmd_ready,
   input  logic                                 dbus_cmd_wr,
   input  logic [ADDR_W-1:0]                    dbus_cmd_addr,
   input  logic [31:0]                          dbus_cmd_wdata,
   input  logic [1:0]                           dbus_cmd_size,
   output logic                                 dbus_rsp_valid,
   output logic [31:0]                          dbus_rsp_data,
   output logic                                 mem_cmd_valid,
   input  logic                                 mem_cmd_ready,
   output logic                                 mem_cmd_instr,
   output logic                                 mem_cmd_wr,
   output logic [ADDR_W-1:0]                    mem_cmd_addr,
   output logic [31:0]                          mem_cmd_wdata,
   output logic [3:0]                           mem_cmd_be,
   input  logic                                 mem_rsp_ready,
   input  logic [31:0]                          mem_rsp_rdata,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
   output logic                                 rsp_orphan_err
);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OW-1:0] MAX_C = OW'(MAX_OUTSTANDING);
   arb_state_e state_q, state_d;
   logic rd_ok, i_req, d_req, sel_d, d_first, hs, push, pop;
   logic head, empty, full, orphan_q, orphan_d;
   always_comb begin
      rd_ok          = outstanding < MAX_C;
      i_req          = ibus_cmd_valid && rd_ok;
      d_req          = dbus_cmd_valid && (dbus_cmd_wr || rd_ok);
      sel_d          = (state_q == ST_GNT_D) || (state_q == ST_IDLE && d_req && (!i_req || d_first));
      mem_cmd_valid  = sel_d ? d_req : i_req;
      hs             = mem_cmd_valid && mem_cmd_ready;
      ibus_cmd_ready = !sel_d && i_req && mem_cmd_ready;
      dbus_cmd_ready = sel_d && d_req && mem_cmd_ready;
      mem_cmd_instr  = !sel_d;
      mem_cmd_wr     = sel_d && dbus_cmd_wr;
      mem_cmd_addr   = sel_d ? dbus_cmd_addr : ibus_cmd_pc;
      mem_cmd_wdata  = sel_d ? dbus_cmd_wdata : 32'h0;
      mem_cmd_be     = sel_d ? byte_en(dbus_cmd_size, dbus_cmd_addr[1:0]) : 4'b1111;
      state_d        = (mem_cmd_valid && !mem_cmd_ready) ? (sel_d ? ST_GNT_D : ST_GNT_I) : ST_IDLE;
      push           = hs && !mem_cmd_wr && !full;
      pop            = mem_rsp_ready && !empty;
      orphan_d       = orphan_q || (mem_rsp_ready && empty);
      ibus_rsp_valid = pop && (head == TAG_IBUS);
      dbus_rsp_valid = pop && (head == TAG_DBUS);
   end
`ifdef CPU_ARB_ROUND_ROBIN_EN
   logic last_q, last_d;
   always_comb begin
      last_d  = hs ? (sel_d ? TAG_DBUS : TAG_IBUS) : last_q;
      d_first = (last_q == TAG_IBUS);
   end
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) last_q <= TAG_DBUS;
      else         last_q <= last_d;
   end
`else
   always_comb d_first = (DBUS_PRIO != 0);
`endif
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q  <= ST_IDLE;
         orphan_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         orphan_q <= orphan_d;
      end
   end
   rsp_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tags (
      .clk    (clk),
      .reset_ (reset_),
      .push   (push),
      .din    (mem_cmd_instr),
      .pop    (pop),
      .head   (head),
      .empty  (empty),
      .full   (full),
      .count  (outstanding)
   );
   assign ibus_rsp_inst  = mem_rsp_rdata;
   assign dbus_rsp_data  = mem_rsp_rdata;
   assign rsp_orphan_err = orphan_q;
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed scenarios then random traffic, each cycle checked
// against a transaction-level model (tag queue + held grant).
module tb_cpu_mem_arbiter;
   localparam int MAX   = 2;
   localparam int DPRIO = 1;
   logic clk = 0, reset_ = 0;
   logic iv = 0, dv = 0, dwr = 0, mrdy = 0, rsp = 0;
   logic [31:0] ipc = 0, daddr = 0, dwd = 0, rdata = 0;
   logic [1:0]  dsz = 0;
   logic ibus_cmd_ready, ibus_rsp_valid, dbus_cmd_ready, dbus_rsp_valid;
   logic mem_cmd_valid, mem_cmd_instr, mem_cmd_wr, rsp_orphan_err;
   logic [31:0] ibus_rsp_inst, dbus_rsp_data, mem_cmd_addr, mem_cmd_wdata;
   logic [3:0]  mem_cmd_be;
   logic [1:0]  outstanding;
   int n_cmp = 0, n_err = 0;
   bit tagq[$];
   int lock = 0;
   bit orph = 0;
   logic o_irdy, o_drdy, o_instr, o_irv, o_drv, o_orph;
   logic [31:0] o_addr;
   logic [3:0]  o_be;
   logic [1:0]  o_out;

   cpu_mem_arbiter #(.ADDR_W(32), .MAX_OUTSTANDING(MAX), .DBUS_PRIO(DPRIO)) dut (
      .clk(clk), .reset_(reset_),
      .ibus_cmd_valid(iv), .ibus_cmd_ready(ibus_cmd_ready), .ibus_cmd_pc(ipc),
      .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_inst(ibus_rsp_inst),
      .dbus_cmd_valid(dv), .dbus_cmd_ready(dbus_cmd_ready), .dbus_cmd_wr(dwr),
      .dbus_cmd_addr(daddr), .dbus_cmd_wdata(dwd), .dbus_cmd_size(dsz),
      .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_data(dbus_rsp_data),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mrdy), .mem_cmd_instr(mem_cmd_instr),
      .mem_cmd_wr(mem_cmd_wr), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
      .mem_cmd_be(mem_cmd_be), .mem_rsp_ready(rsp), .mem_rsp_rdata(rdata),
      .outstanding(outstanding), .rsp_orphan_err(rsp_orphan_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] be_ref(input int sz, input logic [31:0] a);
      int off = int'(a % 4);
      if (sz == 0) return 4'(1 << off);
      if (sz == 1) return 4'(3 << ((off / 2) * 2));
      return 4'hF;
   endfunction

   // Called at posedge+1; checks at the falling edge, then advances the model on the next rising edge.
   task automatic step();
      bit el, iw, dw, eirv, edrv;
      int win;
      #4;
      el = tagq.size() < MAX;
      iw = iv && el;
      dw = dv && (dwr || el);
      if (lock != 0) win = lock;
      else if (dw && (!iw || DPRIO != 0)) win = 2;
      else if (iw) win = 1;
      else win = 0;
      eirv = rsp && tagq.size() > 0 && tagq[0];
      edrv = rsp && tagq.size() > 0 && !tagq[0];
      o_irdy = ibus_cmd_ready; o_drdy = dbus_cmd_ready; o_instr = mem_cmd_instr;
      o_addr = mem_cmd_addr; o_be = mem_cmd_be; o_irv = ibus_rsp_valid;
      o_drv = dbus_rsp_valid; o_out = outstanding; o_orph = rsp_orphan_err;
      chk("cmd_valid", mem_cmd_valid, win != 0);
      chk("ibus_ready", ibus_cmd_ready, win == 1 && mrdy);
      chk("dbus_ready", dbus_cmd_ready, win == 2 && mrdy);
      if (win != 0) begin
         chk("cmd_instr", mem_cmd_instr, win == 1);
         chk("cmd_wr", mem_cmd_wr, win == 2 && dwr);
         chk("cmd_addr", mem_cmd_addr, win == 1 ? ipc : daddr);
         chk("cmd_be", mem_cmd_be, win == 1 ? 4'hF : be_ref(int'(dsz), daddr));
         chk("cmd_wdata", mem_cmd_wdata, win == 1 ? 32'h0 : dwd);
      end
      chk("ibus_rsp_valid", ibus_rsp_valid, eirv);
      chk("dbus_rsp_valid", dbus_rsp_valid, edrv);
      if (eirv) chk("ibus_rsp_inst", ibus_rsp_inst, rdata);
      if (edrv) chk("dbus_rsp_data", dbus_rsp_data, rdata);
      chk("outstanding", outstanding, tagq.size());
      chk("orphan_err", rsp_orphan_err, orph);
      @(posedge clk);
      if (rsp) begin
         if (tagq.size() > 0) void'(tagq.pop_front());
         else orph = 1;
      end
      if (win != 0 && mrdy && !(win == 2 && dwr)) tagq.push_back(win == 1);
      lock = (win != 0 && !mrdy) ? win : 0;
      #1;
   endtask

   task automatic do_reset();
      reset_ = 0; iv = 0; dv = 0; dwr = 0; mrdy = 0; rsp = 0;
      #2;
      chk("rst_cmd_valid", mem_cmd_valid, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_orphan", rsp_orphan_err, 0);
      chk("rst_rsp_valid", {ibus_rsp_valid, dbus_rsp_valid, ibus_cmd_ready, dbus_cmd_ready}, 0);
      @(posedge clk); #1;
      reset_ = 1;
      tagq.delete(); lock = 0; orph = 0;
   endtask

   initial begin
      do_reset();
      // Tie between two reads: dBus first, iBus next cycle; responses routed in order.
      iv = 1; ipc = 32'h100; dv = 1; dwr = 0; daddr = 32'h2000; dsz = 2; mrdy = 1;
      step(); chk("tie_d_first_instr", o_instr, 0); chk("tie_d_first_rdy", o_drdy, 1);
      dv = 0;
      step(); chk("tie_i_next_instr", o_instr, 1); chk("tie_i_next_rdy", o_irdy, 1);
      iv = 0; rsp = 1; rdata = 32'h1111_0000;
      step(); chk("tie_rsp0_d", o_drv, 1);
      rdata = 32'h2222_0000;
      step(); chk("tie_rsp1_i", o_irv, 1);
      rsp = 0;
      // Three back-to-back fetches against a limit of two.
      iv = 1; ipc = 32'h200; step();
      ipc = 32'h204; step();
      ipc = 32'h208; step(); chk("third_held", o_irdy, 0); chk("held_out", o_out, 2);
      rsp = 1; rdata = 32'h0; step(); chk("pop_no_slot_yet", o_irdy, 0);
      rsp = 0; step(); chk("third_accepted", o_irdy, 1);
      iv = 0; rsp = 1; step(); step(); rsp = 0; step();
      // Interleaved fetch/load/fetch with in-order responses.
      iv = 1; ipc = 32'h100; step(); iv = 0;
      dv = 1; dwr = 0; daddr = 32'h2000; step(); dv = 0;
      iv = 1; ipc = 32'h104; rsp = 1; rdata = 32'hAAAA_0000;
      step(); chk("il_rsp_a_i", o_irv, 1); chk("il_fetch_blocked", o_irdy, 0);
      rsp = 0; step(); chk("il_fetch_go", o_irdy, 1); iv = 0;
      rsp = 1; rdata = 32'hBBBB_0000; step(); chk("il_rsp_b_d", o_drv, 1);
      rdata = 32'hCCCC_0000; step(); chk("il_rsp_c_i", o_irv, 1);
      rsp = 0;
      // Byte enables and writes accepted while the tag FIFO is full.
      iv = 1; ipc = 32'h300; step(); ipc = 32'h304; step(); iv = 0;
      dv = 1; dwr = 1; daddr = 32'h3; dsz = 0; dwd = 32'hDEAD_BEEF;
      step(); chk("be_byte3", o_be, 4'b1000); chk("wr_full_rdy", o_drdy, 1);
      daddr = 32'h2; dsz = 1; step(); chk("be_half2", o_be, 4'b1100); chk("wr_full_rdy2", o_drdy, 1);
      dv = 0; rsp = 1; step(); step(); rsp = 0;
      // Stalled dBus grant must not switch to a newly raised iBus.
      dv = 1; dwr = 1; daddr = 32'h4000_0010; dsz = 2; mrdy = 0; step();
      iv = 1; ipc = 32'h500;
      step(); chk("hold_addr1", o_addr, 32'h4000_0010);
      step(); chk("hold_addr2", o_addr, 32'h4000_0010);
      mrdy = 1; step(); chk("hold_hs_addr", o_addr, 32'h4000_0010); chk("hold_hs_rdy", o_drdy, 1);
      dv = 0; step(); chk("after_hold_i", o_irdy, 1);
      // Reset with reads in flight, then a stale response.
      ipc = 32'h600; step(); iv = 0; step(); chk("pre_rst_out", o_out, 2);
      do_reset();
      rsp = 1; rdata = 32'h5555_5555; mrdy = 1;
      step(); chk("orphan_no_i", o_irv, 0); chk("orphan_no_d", o_drv, 0);
      rsp = 0; step(); chk("orphan_sticky", o_orph, 1); chk("orphan_out", o_out, 0);
      // Random traffic with hold-until-ready requesters.
      do_reset();
      o_irdy = 0; o_drdy = 0;
      for (int c = 0; c < 500; c++) begin
         if (!iv || o_irdy) begin
            iv = 1'($urandom_range(0, 1)); ipc = $urandom & 32'hFFFF_FFFC;
         end
         if (!dv || o_drdy) begin
            dv = 1'($urandom_range(0, 1)); dwr = 1'($urandom_range(0, 1));
            daddr = $urandom; dwd = $urandom; dsz = 2'($urandom_range(0, 3));
         end
         mrdy = ($urandom_range(0, 3) != 0);
         rsp = ($urandom_range(0, 2) == 0) && tagq.size() > 0;
         rdata = $urandom;
         step();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
Successor to the single-outstanding CPU iBus/dBus merger. Arbitrates the VexRiscv instruction bus and data bus onto one memory command port. Supports up to MAX_OUTSTANDING in-flight reads, and routes the in-order read responses back to the issuing bus through a tag FIFO. Sits between the CPU core and the memory/peripheral interconnect.

Parameters:
ADDR_W, 32, width of all address buses
MAX_OUTSTANDING, 4, maximum reads issued but not yet answered; range 1..16; tag FIFO depth
DBUS_PRIO, 1, fixed-priority winner when both buses request: 1 = dBus, 0 = iBus

Ports:
clk  in  1  clock
reset_  in  1  asynchronous active-low reset
ibus_cmd_valid  in  1  instruction fetch request
ibus_cmd_ready  out  1  fetch accepted
ibus_cmd_pc  in  ADDR_W  fetch address
ibus_rsp_valid  out  1  fetch data valid
ibus_rsp_inst  out  32  fetch data
dbus_cmd_valid  in  1  data request
dbus_cmd_ready  out  1  data request accepted
dbus_cmd_wr  in  1  1 = write
dbus_cmd_addr  in  ADDR_W  data address
dbus_cmd_wdata  in  32  write data
dbus_cmd_size  in  2  0 = byte, 1 = half, 2 = word
dbus_rsp_valid  out  1  load data valid
dbus_rsp_data  out  32  load data
mem_cmd_valid  out  1  memory command valid
mem_cmd_ready  in  1  memory accepts command
mem_cmd_instr  out  1  command originates from iBus
mem_cmd_wr  out  1  write
mem_cmd_addr  out  ADDR_W  address
mem_cmd_wdata  out  32  write data
mem_cmd_be  out  4  byte enables
mem_rsp_ready  in  1  read response valid (single cycle, in order)
mem_rsp_rdata  in  32  read data
outstanding  out  clog2(MAX_OUTSTANDING+1)  current read count
rsp_orphan_err  out  1  sticky: response arrived with no read outstanding

Behaviour:
- Reset (async, reset_=0):
  - grant register idle; tag FIFO empty; outstanding = 0; rsp_orphan_err = 0.
  - mem_cmd_valid, ibus_cmd_ready, dbus_cmd_ready, ibus_rsp_valid and dbus_rsp_valid are all 0.
  - Reset mid-operation discards every in-flight tag.
- Arbitration FSM: states IDLE, GNT_I, GNT_D.
  - IDLE: pick the requester. If both request, the winner is set by DBUS_PRIO.
  - Drive mem_cmd_* combinationally from the winning request in the same cycle. Command latency is 0.
  - If mem_cmd_valid && !mem_cmd_ready, latch the grant (GNT_I or GNT_D). The grant holds until the handshake; the other bus is never switched in mid-handshake.
  - On handshake, return to IDLE.
- Eligibility:
  - A read (any iBus command, or a dBus command with wr=0) is eligible only when outstanding < MAX_OUTSTANDING, using the registered count. A pop in the same cycle does not free a slot until the next cycle.
  - Writes are always eligible.
  - An ineligible requester does not raise mem_cmd_valid and does not block the other bus while IDLE.
- ready: x_cmd_ready = granted-or-winning && eligible && mem_cmd_ready.
- Byte enables:
  - size 0: 4'b0001 << addr[1:0]
  - size 1: 4'b0011 << {addr[1],1'b0}
  - size 2 or 3: 4'b1111
  - iBus commands: be = 4'b1111, wr = 0, wdata = 0.
- Tag FIFO:
  - Push {instr} on every accepted read.
  - Pop on mem_rsp_ready.
  - ibus_rsp_valid = mem_rsp_ready && !empty && head==1; dbus_rsp_valid = mem_rsp_ready && !empty && head==0.
  - rsp data is mem_rsp_rdata passed straight through.
- Simultaneous push and pop: count unchanged, FIFO pointers both advance.
- Orphan response: mem_rsp_ready with FIFO empty → dropped, no rsp_valid, rsp_orphan_err set until reset.
- Counters and pointers wrap modulo the FIFO depth. outstanding never exceeds MAX_OUTSTANDING and never underflows.

Optional Feature:
CPU_ARB_ROUND_ROBIN_EN
- Defined: on a tie, the bus not granted last wins (1-bit last-grant register, reset to dBus-last). DBUS_PRIO is ignored.
- Undefined: fixed priority per DBUS_PRIO.

Decomposition:
- Package cpu_bus_pkg holds:
  - size encodings (SIZE_B/H/W)
  - a byte-enable function
  - arbiter state encodings
  - tag constants TAG_IBUS = 1, TAG_DBUS = 0
- One sub-module, rsp_tag_fifo: parametrised depth, 1-bit wide; provides push, pop, empty, full and count.

Test Plan:
- Both buses valid, DBUS_PRIO=1, mem_cmd_ready=1 → dBus handshakes first (mem_cmd_instr=0); iBus handshakes the next cycle (instr=1).
- MAX_OUTSTANDING=2: three back-to-back iBus fetches, no responses → two accepted; third held with ibus_cmd_ready=0, outstanding=2; one response → third accepted the cycle after.
- Interleaved fetch@0x100, load@0x2000, fetch@0x104; responses 0xAAAA0000/0xBBBB0000/0xCCCC0000 → iBus, dBus, iBus receive them in that order.
- dbus byte write addr 0x3 → be=4'b1000; half write addr 0x2 → be=4'b1100; writes accepted while FIFO full.
- mem_cmd_ready=0 for 3 cycles during a dBus grant, iBus raised meanwhile → mem_cmd_addr stays on the dBus address until the handshake.
- Reset asserted with 2 reads outstanding, then one mem_rsp_ready after release → no rsp_valid, rsp_orphan_err=1, outstanding=0.
